// File: rtl/store_drain_gate_pkg.sv
// Shared types for the store drain gate: gate configuration, FSM states and
// the non-idempotent region match helpers.
package store_drain_gate_pkg;

  localparam int unsigned MAX_RULES = 4;

  typedef struct packed {
    logic [31:0]                  max_outstanding_stores;
    logic [31:0]                  nr_ni_rules;
    logic [MAX_RULES-1:0][63:0]   ni_base;
    logic [MAX_RULES-1:0][63:0]   ni_len;
  } gate_cfg_t;

  localparam gate_cfg_t DEFAULT_CFG = '{
    max_outstanding_stores: 32'd7,
    nr_ni_rules:            32'd1,
    ni_base:                '{64'h0, 64'h0, 64'h0, 64'h0000_0000_1000_0000},
    ni_len:                 '{64'h0, 64'h0, 64'h0, 64'h0000_0000_0000_1000}
  };

  typedef enum logic [2:0] {
    IDLE,
    NI_DRAIN,
    NI_ISSUE,
    NI_WAIT,
    FENCE_DRAIN
  } gate_state_e;

  // Offset compare avoids overflow of base+len at the top of the address space.
  function automatic logic range_hit(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] len);
    return (len != 64'h0) && (addr >= base) && ((addr - base) < len);
  endfunction

  function automatic logic ni_match(input gate_cfg_t cfg, input logic [63:0] addr);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < MAX_RULES; i++) begin
      if ((i < cfg.nr_ni_rules) && range_hit(addr, cfg.ni_base[i], cfg.ni_len[i])) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/store_drain_gate_pma_range_match.sv
// Combinational N-rule base/length address matcher; usable for any PMA-style
// region check (non-idempotent, cached, executable).
module pma_range_match
  import store_drain_gate_pkg::*;
#(
  parameter int unsigned                NrRules = 1,
  parameter logic [MAX_RULES-1:0][63:0] Base    = '0,
  parameter logic [MAX_RULES-1:0][63:0] Len     = '0
) (
  input  logic [63:0] i_addr,
  output logic        o_match
);

  always_comb begin
    // NOTE: default every always_comb output before any branch so no path infers a latch.
    o_match = 1'b0;
    for (int unsigned i = 0; i < MAX_RULES; i++) begin
      if ((i < NrRules) && range_hit(i_addr, Base[i], Len[i])) o_match = 1'b1;
    end
  end

endmodule

// File: rtl/store_drain_gate.sv
// Store/load gate in front of the write-through dcache: caps in-flight stores,
// serialises non-idempotent loads and drains stores for fences.
// Optional stall statistics output enabled by STORE_DRAIN_GATE_STATS_EN.
module store_drain_gate
  import store_drain_gate_pkg::*;
#(
  parameter gate_cfg_t   CVA6Cfg  = DEFAULT_CFG,
  parameter int unsigned CntWidth = $clog2(CVA6Cfg.max_outstanding_stores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  output logic                st_valid_o,
  input  logic                st_ready_i,
  input  logic                st_ack_i,
  input  logic                ld_valid_i,
  input  logic [63:0]         ld_addr_i,
  output logic                ld_ready_o,
  output logic                ld_valid_o,
  input  logic                ld_ready_i,
  input  logic                ld_rsp_valid_i,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic [CntWidth-1:0] outstanding_o
`ifdef STORE_DRAIN_GATE_STATS_EN
  ,
  output logic [31:0]         stall_cycles_o
`endif
);

  localparam logic [CntWidth-1:0] MAX_CNT = CntWidth'(CVA6Cfg.max_outstanding_stores);

  gate_state_e         r_state, w_state_next;
  logic [CntWidth-1:0] r_cnt, w_cnt_next;
  logic                r_fence_done, w_fence_done_next;
  logic                w_ni, w_allow_st, w_st_inc, w_st_dec;

  pma_range_match #(
    .NrRules (CVA6Cfg.nr_ni_rules),
    .Base    (CVA6Cfg.ni_base),
    .Len     (CVA6Cfg.ni_len)
  ) u_ni_match (
    .i_addr  (ld_addr_i),
    .o_match (w_ni)
  );

  // Slot check uses the registered count: a same-cycle ack frees nothing.
  assign w_allow_st = (r_cnt < MAX_CNT) && (r_state == IDLE);
  assign st_valid_o = st_valid_i & w_allow_st;
  assign st_ready_o = st_ready_i & w_allow_st;
  assign w_st_inc   = st_valid_o & st_ready_i;
  assign w_st_dec   = st_ack_i & (r_cnt != '0);

  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_st_inc, w_st_dec})
      2'b10:   w_cnt_next = r_cnt + CntWidth'(1);
      2'b01:   w_cnt_next = r_cnt - CntWidth'(1);
      default: w_cnt_next = r_cnt;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_fence_done_next = 1'b0;
    ld_valid_o        = 1'b0;
    ld_ready_o        = 1'b0;
    case (r_state)
      IDLE: begin
        ld_valid_o = ld_valid_i & ~w_ni;
        ld_ready_o = ld_ready_i & ~w_ni;
        if (fence_i) begin
          // Nothing left to drain: answer the fence on the next cycle directly.
          if (w_cnt_next == '0) w_fence_done_next = 1'b1;
          else                  w_state_next      = FENCE_DRAIN;
        end else if (ld_valid_i && w_ni) begin
          w_state_next = NI_DRAIN;
        end
      end
      NI_DRAIN: begin
        if (flush_i)                 w_state_next = IDLE;
        else if (w_cnt_next == '0)   w_state_next = NI_ISSUE;
      end
      NI_ISSUE: begin
        ld_valid_o = ld_valid_i;
        ld_ready_o = ld_ready_i;
        // An accepted load must have its response consumed even if flushed.
        if (ld_valid_i && ld_ready_i) w_state_next = NI_WAIT;
        else if (flush_i)             w_state_next = IDLE;
      end
      NI_WAIT: begin
        if (ld_rsp_valid_i) w_state_next = IDLE;
      end
      FENCE_DRAIN: begin
        if (flush_i) begin
          w_state_next = IDLE;
        end else if (w_cnt_next == '0) begin
          w_fence_done_next = 1'b1;
          w_state_next      = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_fence_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_fence_done <= w_fence_done_next;
    end
  end

  assign outstanding_o = r_cnt;
  assign fence_done_o  = r_fence_done;

`ifdef STORE_DRAIN_GATE_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        r_stall_cycles <= '0;
    else if (st_valid_i && !w_allow_st) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles_o = r_stall_cycles;
`endif

endmodule

// File: tb/tb_store_drain_gate.sv
// Directed bench for store_drain_gate: cycle-by-cycle vector table plus
// hand-written flush and mid-fence reset sequences.
module tb_store_drain_gate;

  localparam logic [63:0] A_NI   = 64'h0000_0000_1000_0010;
  localparam logic [63:0] A_END  = 64'h0000_0000_1000_1000;
  localparam logic [63:0] A_LOW  = 64'h0000_0000_0FFF_FFFF;
  localparam logic [63:0] A_IDEM = 64'h0000_0000_0000_2000;

  typedef struct {
    logic        sv, sr, ack, lv;
    logic [63:0] addr;
    logic        lr, rsp, fen, fl;
    logic        e_stv, e_str, e_ldv, e_ldr, e_done;
    logic [2:0]  e_cnt;
  } vec_t;

  logic        clk_i, rst_ni, flush_i;
  logic        st_valid_i, st_ready_o, st_valid_o, st_ready_i, st_ack_i;
  logic        ld_valid_i, ld_ready_o, ld_valid_o, ld_ready_i, ld_rsp_valid_i;
  logic [63:0] ld_addr_i;
  logic        fence_i, fence_done_o;
  logic [2:0]  outstanding_o;
`ifdef STORE_DRAIN_GATE_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  store_drain_gate dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .st_valid_i     (st_valid_i),
    .st_ready_o     (st_ready_o),
    .st_valid_o     (st_valid_o),
    .st_ready_i     (st_ready_i),
    .st_ack_i       (st_ack_i),
    .ld_valid_i     (ld_valid_i),
    .ld_addr_i      (ld_addr_i),
    .ld_ready_o     (ld_ready_o),
    .ld_valid_o     (ld_valid_o),
    .ld_ready_i     (ld_ready_i),
    .ld_rsp_valid_i (ld_rsp_valid_i),
    .fence_i        (fence_i),
    .fence_done_o   (fence_done_o),
    .outstanding_o  (outstanding_o)
`ifdef STORE_DRAIN_GATE_STATS_EN
    ,
    .stall_cycles_o (stall_cycles)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, sr, ack, lv, input logic [63:0] addr,
                       input logic lr, rsp, fen, fl);
    st_valid_i     = sv;
    st_ready_i     = sr;
    st_ack_i       = ack;
    ld_valid_i     = lv;
    ld_addr_i      = addr;
    ld_ready_i     = lr;
    ld_rsp_valid_i = rsp;
    fence_i        = fen;
    flush_i        = fl;
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic to_sample();
    @(negedge clk_i);
  endtask

  task automatic to_next();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic sv, sr, ack, lv, input logic [63:0] addr,
                              input logic lr, rsp, fen, fl,
                              input logic e_stv, e_str, e_ldv, e_ldr, e_done,
                              input logic [2:0] e_cnt);
    vec_t v;
    v.sv = sv; v.sr = sr; v.ack = ack; v.lv = lv; v.addr = addr;
    v.lr = lr; v.rsp = rsp; v.fen = fen; v.fl = fl;
    v.e_stv = e_stv; v.e_str = e_str; v.e_ldv = e_ldv; v.e_ldr = e_ldr;
    v.e_done = e_done; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    // Reset state
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,3'd0));
    // 1. fill to the cap, ack without bypass, then accept the 8th
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1,1,0,0,0,0,0,0,0, 1,1,0,0,0,3'(i)));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,0, 0,0,0,0,0,3'd7));
    vecs.push_back(mk(1,1,1,0,0,0,0,0,0, 0,0,0,0,0,3'd7));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,0, 1,1,0,0,0,3'd6));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0,0,0,3'(7 - i)));
    // 2. handshake and ack together at cnt=3
    vecs.push_back(mk(1,1,1,0,0,0,0,0,0, 1,1,0,0,0,3'd3));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,3'd3));
    // 3. NI load with cnt=2
    vecs.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0,0,0,3'd3));
    vecs.push_back(mk(0,0,0,1,A_NI,1,0,0,0, 0,0,0,0,0,3'd2));
    vecs.push_back(mk(1,1,0,1,A_NI,1,0,0,0, 0,0,0,0,0,3'd2));
    vecs.push_back(mk(1,1,1,1,A_NI,1,0,0,0, 0,0,0,0,0,3'd2));
    vecs.push_back(mk(1,1,1,1,A_NI,1,0,0,0, 0,0,0,0,0,3'd1));
    vecs.push_back(mk(1,1,0,1,A_NI,0,0,0,0, 0,0,1,0,0,3'd0));
    vecs.push_back(mk(0,0,0,1,A_NI,1,0,0,0, 0,0,1,1,0,3'd0));
    vecs.push_back(mk(1,1,0,1,A_NI,1,0,0,0, 0,0,0,0,0,3'd0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0, 0,0,0,0,0,3'd0));
    vecs.push_back(mk(1,1,0,1,A_IDEM,1,0,0,0, 1,1,1,1,0,3'd0));
    // 4. range end and just-below-base addresses pass with cnt=5
    for (int i = 1; i < 5; i++) vecs.push_back(mk(1,1,0,0,0,0,0,0,0, 1,1,0,0,0,3'(i)));
    vecs.push_back(mk(0,0,0,1,A_END,1,0,0,0, 0,0,1,1,0,3'd5));
    vecs.push_back(mk(0,0,0,1,A_LOW,1,0,0,0, 0,0,1,1,0,3'd5));
    // 5. fence with cnt=4, then fence with cnt=0
    vecs.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0,0,0,3'd5));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0, 0,0,0,0,0,3'd4));
    vecs.push_back(mk(1,1,0,0,0,0,0,0,0, 0,0,0,0,0,3'd4));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0,0,0,3'(4 - i)));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,1,3'd0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,3'd0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,0, 0,0,0,0,0,3'd0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,1,3'd0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,3'd0));
    // Ack at cnt=0 saturates
    vecs.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,0,0,0,3'd0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,3'd0));

    rst_ni = 1'b0;
    drive(0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    to_next();

    foreach (vecs[i]) begin
      drive(vecs[i].sv, vecs[i].sr, vecs[i].ack, vecs[i].lv, vecs[i].addr,
            vecs[i].lr, vecs[i].rsp, vecs[i].fen, vecs[i].fl);
      to_sample();
      check($sformatf("v%0d st_valid_o", i),    64'(st_valid_o),    64'(vecs[i].e_stv));
      check($sformatf("v%0d st_ready_o", i),    64'(st_ready_o),    64'(vecs[i].e_str));
      check($sformatf("v%0d ld_valid_o", i),    64'(ld_valid_o),    64'(vecs[i].e_ldv));
      check($sformatf("v%0d ld_ready_o", i),    64'(ld_ready_o),    64'(vecs[i].e_ldr));
      check($sformatf("v%0d fence_done_o", i),  64'(fence_done_o),  64'(vecs[i].e_done));
      check($sformatf("v%0d outstanding_o", i), 64'(outstanding_o), 64'(vecs[i].e_cnt));
      to_next();
    end

    // 6a. flush during NI_DRAIN with one store outstanding
    drive(1,1,0,0,0,0,0,0,0);
    to_next();
    drive(0,0,0,1,A_NI,1,0,0,0);
    to_sample();
    check("flush ni held ld_ready_o", 64'(ld_ready_o), 64'd0);
    to_next();
    drive(1,1,0,1,A_NI,1,0,0,1);
    to_sample();
    check("flush drain ld_valid_o", 64'(ld_valid_o), 64'd0);
    check("flush drain st_ready_o", 64'(st_ready_o), 64'd0);
    to_next();
    drive(1,0,0,0,0,0,0,0,0);
    to_sample();
    check("flush idle st_valid_o", 64'(st_valid_o), 64'd1);
    check("flush idle outstanding", 64'(outstanding_o), 64'd1);
    check("flush idle fence_done", 64'(fence_done_o), 64'd0);
    to_next();
    drive(0,0,1,1,A_IDEM,1,0,0,0);
    to_sample();
    check("flush idle ld_valid_o", 64'(ld_valid_o), 64'd1);
    to_next();
    drive(0,0,0,0,0,0,0,0,0);
    to_sample();
    check("late ack outstanding", 64'(outstanding_o), 64'd0);
    to_next();

    // 6b. async reset in the middle of a fence drain
    drive(1,1,0,0,0,0,0,0,0);
    to_next();
    to_next();
    drive(0,0,0,0,0,0,0,1,0);
    to_next();
    drive(1,1,0,0,0,0,0,0,0);
    to_sample();
    check("fence drain st_valid_o", 64'(st_valid_o), 64'd0);
    check("fence drain outstanding", 64'(outstanding_o), 64'd2);
    to_next();
    drive(0,0,0,0,0,0,0,0,0);
    rst_ni = 1'b0;
    #1;
    check("rst outstanding_o", 64'(outstanding_o), 64'd0);
    check("rst fence_done_o", 64'(fence_done_o), 64'd0);
    check("rst st_valid_o", 64'(st_valid_o), 64'd0);
    check("rst ld_valid_o", 64'(ld_valid_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    to_next();
    drive(0,0,1,0,0,0,0,0,0);
    to_sample();
    check("post rst fence_done_o", 64'(fence_done_o), 64'd0);
    to_next();
    drive(1,0,0,0,0,0,0,0,0);
    to_sample();
    check("post rst dropped ack", 64'(outstanding_o), 64'd0);
    check("post rst idle st_valid_o", 64'(st_valid_o), 64'd1);
    check("post rst fence_done_o 2", 64'(fence_done_o), 64'd0);
    to_next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
